// File: rtl/stream_demux_if.sv
// Stream bundle for the 1-to-N demultiplexer: one valid/ready input stream and
// NUM_CH valid/ready output channels sharing a single data/last register.
interface stream_demux_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) ();
    logic [DATA_W-1:0]        s_data;
    logic [SEL_W-1:0]         s_sel;
    logic                     s_last;
    logic                     s_valid;
    logic                     s_ready;
    logic [NUM_CH*DATA_W-1:0] m_data;
    logic [NUM_CH-1:0]        m_last;
    logic [NUM_CH-1:0]        m_valid;
    logic [NUM_CH-1:0]        m_ready;

    // Demux side: consumes the s_* stream, produces the m_* channels.
    modport slave (
        input  s_data, s_sel, s_last, s_valid, m_ready,
        output s_ready, m_data, m_last, m_valid
    );

    // Source/consumer side, as seen by whatever surrounds the demux.
    modport master (
        output s_data, s_sel, s_last, s_valid, m_ready,
        input  s_ready, m_data, m_last, m_valid
    );
endinterface

// File: rtl/stream_demux_1ton.sv
// Parametrised 1-to-NUM_CH packet demux with a single registered output stage.
// Optional macro STREAM_DEMUX_DROP_CNT_EN adds a saturating dropped-packet counter.
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic        clk,
    input  logic        rst,
    stream_demux_if.slave bus,
    output logic        busy,
    output logic        err_sel,
`ifdef STREAM_DEMUX_DROP_CNT_EN
    output logic [15:0] drop_cnt,
`endif
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ROUTE = 2'd1, DROP = 2'd2} state_t;

    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    state_t             state;
    logic               out_vld;
    logic [SEL_W-1:0]   out_ch;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;

    logic sel_ready;
    logic can_load;
    logic accept;
    logic sel_ok;

    // Handshake: a beat transfers on any edge where valid && ready are both 1;
    // ready never depends on valid on the same interface.
    always_comb begin
        sel_ready   = 1'b0;
        bus.m_valid = '0;
        bus.m_last  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (out_ch == SEL_W'(k)) begin
                sel_ready      = bus.m_ready[k];
                bus.m_valid[k] = out_vld;
                bus.m_last[k]  = out_vld && out_last;
            end
        end
    end

    assign bus.m_data  = {NUM_CH{out_data}};
    assign can_load    = !out_vld || sel_ready;
    assign bus.s_ready = (state == DROP) ? 1'b1 : can_load;
    assign accept      = bus.s_valid && bus.s_ready;
    assign sel_ok      = {1'b0, bus.s_sel} < NUM_CH_W;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            out_vld  <= 1'b0;
            out_ch   <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            err_sel  <= 1'b0;
        end else begin
            err_sel <= 1'b0;
            if (out_vld && sel_ready)
                out_vld <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (sel_ok) begin
                            out_vld  <= 1'b1;
                            out_ch   <= bus.s_sel;
                            out_data <= bus.s_data;
                            out_last <= bus.s_last;
                            state    <= bus.s_last ? IDLE : ROUTE;
                        end else begin
                            err_sel  <= 1'b1;
                            state    <= bus.s_last ? IDLE : DROP;
                        end
                    end
                    // out_ch still holds the channel latched on the first beat.
                    ROUTE: begin
                        out_vld  <= 1'b1;
                        out_data <= bus.s_data;
                        out_last <= bus.s_last;
                        if (bus.s_last)
                            state <= IDLE;
                    end
                    DROP: begin
                        if (bus.s_last)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (accept && state == IDLE && !sel_ok && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for stream_demux_1ton: a 4-channel instance for routing and
// backpressure, and a 3-channel instance for out-of-range select handling.
module tb_stream_demux_1ton;
    logic clk;
    logic rst;

    logic       busy_a, err_sel_a, busy_b, err_sel_b;
    logic [1:0] dbg_state_a, dbg_state_b;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt_a, drop_cnt_b;
`endif

    int tests;
    int failed;

    stream_demux_if #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) bus_a ();
    stream_demux_if #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) bus_b ();

    stream_demux_1ton #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .busy(busy_a), .err_sel(err_sel_a),
`ifdef STREAM_DEMUX_DROP_CNT_EN
        .drop_cnt(drop_cnt_a),
`endif
        .dbg_state(dbg_state_a)
    );

    stream_demux_1ton #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .busy(busy_b), .err_sel(err_sel_b),
`ifdef STREAM_DEMUX_DROP_CNT_EN
        .drop_cnt(drop_cnt_b),
`endif
        .dbg_state(dbg_state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks happen on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        bus_a.s_valid = v;
        bus_a.s_sel   = sel;
        bus_a.s_data  = d;
        bus_a.s_last  = l;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        bus_b.s_valid = v;
        bus_b.s_sel   = sel;
        bus_b.s_data  = d;
        bus_b.s_last  = l;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);
        bus_a.m_ready = 4'hF;
        bus_b.m_ready = 3'h7;

        // Test 1: reset state
        tick();
        tick();
        rst = 1'b0;
        sample();
        check("t1_m_valid_a", bus_a.m_valid, 4'h0);
        check("t1_m_last_a", bus_a.m_last, 4'h0);
        check("t1_m_data_a", bus_a.m_data, 32'h0);
        check("t1_busy_a", busy_a, 1'b0);
        check("t1_err_a", err_sel_a, 1'b0);
        check("t1_s_ready_a", bus_a.s_ready, 1'b1);
        check("t1_state_a", dbg_state_a, 2'd0);
        check("t1_m_valid_b", bus_b.m_valid, 3'h0);
        check("t1_s_ready_b", bus_b.s_ready, 1'b1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("t1_drop_cnt_b", drop_cnt_b, 16'd0);
`endif

        // Test 2: 3-beat packet to ch2, all ready
        tick();
        drive_a(1'b1, 2'd2, 8'h11, 1'b0);
        sample();
        check("t2_s_ready0", bus_a.s_ready, 1'b1);
        tick();
        drive_a(1'b1, 2'd1, 8'h22, 1'b0);
        sample();
        check("t2_valid0", bus_a.m_valid, 4'b0100);
        check("t2_data0", bus_a.m_data[2*8 +: 8], 8'h11);
        check("t2_last0", bus_a.m_last, 4'b0000);
        check("t2_busy0", busy_a, 1'b1);
        tick();
        drive_a(1'b1, 2'd3, 8'h33, 1'b1);
        sample();
        check("t2_valid1", bus_a.m_valid, 4'b0100);
        check("t2_data1", bus_a.m_data[2*8 +: 8], 8'h22);
        tick();
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        sample();
        check("t2_valid2", bus_a.m_valid, 4'b0100);
        check("t2_data2", bus_a.m_data[2*8 +: 8], 8'h33);
        check("t2_last2", bus_a.m_last, 4'b0100);
        check("t2_busy2", busy_a, 1'b0);
        tick();
        sample();
        check("t2_drained", bus_a.m_valid, 4'b0000);

        // Test 3: ch1 stalled for 4 cycles, other channels' ready ignored
        tick();
        bus_a.m_ready = 4'b1101;
        drive_a(1'b1, 2'd1, 8'hA1, 1'b0);
        sample();
        check("t3_s_ready0", bus_a.s_ready, 1'b1);
        tick();
        drive_a(1'b1, 2'd0, 8'hA2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            sample();
            check("t3_hold_valid", bus_a.m_valid, 4'b0010);
            check("t3_hold_data", bus_a.m_data[1*8 +: 8], 8'hA1);
            check("t3_hold_s_ready", bus_a.s_ready, 1'b0);
            if (i < 3)
                tick();
        end
        tick();
        bus_a.m_ready = 4'hF;
        sample();
        check("t3_pass_s_ready", bus_a.s_ready, 1'b1);
        check("t3_pass_data", bus_a.m_data[1*8 +: 8], 8'hA1);
        tick();
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        sample();
        check("t3_valid2", bus_a.m_valid, 4'b0010);
        check("t3_data2", bus_a.m_data[1*8 +: 8], 8'hA2);
        check("t3_last2", bus_a.m_last, 4'b0010);
        tick();
        sample();
        check("t3_drained", bus_a.m_valid, 4'b0000);

        // Test 4: NUM_CH=3, sel=3 packets are dropped
        tick();
        drive_b(1'b1, 2'd3, 8'h55, 1'b0);
        sample();
        check("t4_s_ready0", bus_b.s_ready, 1'b1);
        tick();
        drive_b(1'b1, 2'd0, 8'h66, 1'b1);
        sample();
        check("t4_err0", err_sel_b, 1'b1);
        check("t4_valid0", bus_b.m_valid, 3'b000);
        check("t4_busy0", busy_b, 1'b1);
        check("t4_state0", dbg_state_b, 2'd2);
        check("t4_s_ready1", bus_b.s_ready, 1'b1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("t4_cnt0", drop_cnt_b, 16'd1);
`endif
        tick();
        drive_b(1'b1, 2'd3, 8'h77, 1'b1);
        sample();
        check("t4_err1", err_sel_b, 1'b0);
        check("t4_valid1", bus_b.m_valid, 3'b000);
        check("t4_busy1", busy_b, 1'b0);
        tick();
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);
        sample();
        check("t4_err_single", err_sel_b, 1'b1);
        check("t4_busy_single", busy_b, 1'b0);
        check("t4_valid_single", bus_b.m_valid, 3'b000);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("t4_cnt1", drop_cnt_b, 16'd2);
`endif
        tick();
        sample();
        check("t4_err_clear", err_sel_b, 1'b0);

        // Test 5: back-to-back single-beat packets sel=0,3,1
        drive_a(1'b1, 2'd0, 8'h01, 1'b1);
        tick();
        drive_a(1'b1, 2'd3, 8'h03, 1'b1);
        sample();
        check("t5_valid0", bus_a.m_valid, 4'b0001);
        check("t5_data0", bus_a.m_data[0*8 +: 8], 8'h01);
        check("t5_s_ready0", bus_a.s_ready, 1'b1);
        tick();
        drive_a(1'b1, 2'd1, 8'h02, 1'b1);
        sample();
        check("t5_valid1", bus_a.m_valid, 4'b1000);
        check("t5_data1", bus_a.m_data[3*8 +: 8], 8'h03);
        check("t5_last1", bus_a.m_last, 4'b1000);
        tick();
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        sample();
        check("t5_valid2", bus_a.m_valid, 4'b0010);
        check("t5_data2", bus_a.m_data[1*8 +: 8], 8'h02);
        check("t5_busy2", busy_a, 1'b0);
        tick();
        sample();
        check("t5_drained", bus_a.m_valid, 4'b0000);

        // Test 6: reset in the middle of a 4-beat sel=2 packet
        drive_a(1'b1, 2'd2, 8'hB1, 1'b0);
        tick();
        drive_a(1'b1, 2'd2, 8'hB2, 1'b0);
        sample();
        check("t6_valid0", bus_a.m_valid, 4'b0100);
        tick();
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        rst = 1'b1;
        sample();
        check("t6_pre_rst_data", bus_a.m_data[2*8 +: 8], 8'hB2);
        check("t6_pre_rst_busy", busy_a, 1'b1);
        tick();
        rst = 1'b0;
        drive_a(1'b1, 2'd0, 8'hC1, 1'b1);
        sample();
        check("t6_rst_valid", bus_a.m_valid, 4'b0000);
        check("t6_rst_data", bus_a.m_data, 32'h0);
        check("t6_rst_busy", busy_a, 1'b0);
        check("t6_rst_s_ready", bus_a.s_ready, 1'b1);
        tick();
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        sample();
        check("t6_valid1", bus_a.m_valid, 4'b0001);
        check("t6_data1", bus_a.m_data[0*8 +: 8], 8'hC1);
        check("t6_last1", bus_a.m_last, 4'b0001);
        tick();
        sample();
        check("t6_drained", bus_a.m_valid, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
